// File: rtl/gzip_regs_pkg.sv
// Shared definitions for the gzip compressor register map and its AXI4-Lite initiator.
package gzip_regs_pkg;

    localparam logic [7:0] REG_CTRL    = 8'h00;
    localparam logic [7:0] REG_BTYPE   = 8'h04;
    localparam logic [7:0] REG_STATUS  = 8'h08;
    localparam logic [7:0] REG_ISIZE   = 8'h0C;
    localparam logic [7:0] REG_CRC32   = 8'h10;
    localparam logic [7:0] REG_BLKSIZE = 8'h14;

    localparam logic [7:0] DEVICE_ID   = 8'hB9;

    localparam logic [1:0] AXI_OKAY    = 2'b00;
    localparam logic [1:0] AXI_SLVERR  = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } axil_state_t;

endpackage

// File: rtl/gzip_axi4l_master.sv
// Single-outstanding AXI4-Lite initiator: one register command in, one response out,
// with a sticky watchdog flag for slaves that stall.
module gzip_axi4l_master
    import gzip_regs_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_write,
    output logic                    timeout_err,

    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,

    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,

    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [1:0]              m_bresp,

    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,

    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    axil_state_t      state;
    logic [CNT_W-1:0] wd_cnt;
    logic [ADDR_WIDTH-1:0] addr_aligned;

    assign addr_aligned = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
    assign m_awprot     = 3'b000;
    assign m_arprot     = 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_resp    <= '0;
            rsp_write   <= 1'b0;
            timeout_err <= 1'b0;
            m_awvalid   <= 1'b0;
            m_awaddr    <= '0;
            m_wvalid    <= 1'b0;
            m_wdata     <= '0;
            m_wstrb     <= '0;
            m_bready    <= 1'b0;
            m_arvalid   <= 1'b0;
            m_araddr    <= '0;
            m_rready    <= 1'b0;
        end else begin
            // Saturating watchdog; the transaction keeps running after it fires.
            if (state != IDLE && wd_cnt != TMO) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (TIMEOUT_CYCLES != 0 && (wd_cnt + 1'b1) == TMO)
                    timeout_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready   <= 1'b0;
                        timeout_err <= 1'b0;
                        wd_cnt      <= '0;
                        rsp_write   <= cmd_write;
                        if (cmd_write) begin
                            m_awaddr  <= addr_aligned;
                            m_wdata   <= cmd_wdata;
                            m_wstrb   <= '1;
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            m_araddr  <= addr_aligned;
                            m_arvalid <= 1'b1;
                            state     <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // A low valid here means that channel already handshook.
                    if (m_awvalid && m_awready) m_awvalid <= 1'b0;
                    if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
                    if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
                        m_bready <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_bvalid) begin
                        m_bready  <= 1'b0;
                        rsp_resp  <= m_bresp;
                        rsp_data  <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (m_rvalid) begin
                        m_rready  <= 1'b0;
                        rsp_data  <= m_rdata;
                        rsp_resp  <= m_rresp;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
